// File: rtl/writeback_stage_if.sv
// Memory-stage to writeback-stage bundle: captured instruction fields in,
// register-file write / forward port, misalignment flag and retire count out.
interface writeback_stage_if #(parameter int INSTRET_W = 64);
   logic                 stall;
   logic                 flush;
   logic                 in_valid;
   logic                 in_reg_write;
   logic [4:0]           in_addr_rd;
   logic [1:0]           in_wb_sel;
   logic [2:0]           in_funct3;
   logic [31:0]          in_alu_result;
   logic [31:0]          in_mem_rdata;
   logic [31:0]          in_pc;

   logic                 write_enable;
   logic [4:0]           addr_rd;
   logic [31:0]          data_rd;
   logic                 fwd_valid;
   logic [4:0]           fwd_addr;
   logic [31:0]          fwd_data;
   logic                 misalign_err;
   logic [INSTRET_W-1:0] instret;

   modport master (
      output stall, flush, in_valid, in_reg_write, in_addr_rd, in_wb_sel,
             in_funct3, in_alu_result, in_mem_rdata, in_pc,
      input  write_enable, addr_rd, data_rd, fwd_valid, fwd_addr, fwd_data,
             misalign_err, instret
   );

   modport slave (
      input  stall, flush, in_valid, in_reg_write, in_addr_rd, in_wb_sel,
             in_funct3, in_alu_result, in_mem_rdata, in_pc,
      output write_enable, addr_rd, data_rd, fwd_valid, fwd_addr, fwd_data,
             misalign_err, instret
   );
endinterface

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register with load alignment/extension, result select,
// register-file write and forward ports, and the retired-instruction counter.
module writeback_stage #(
   parameter int INSTRET_W = 64
) (
   input  logic               clock,
   input  logic               reset_n,
   writeback_stage_if.slave   wb
);

   logic                 valid_q, valid_d;
   logic                 reg_write_q, reg_write_d;
   logic [4:0]           addr_rd_q, addr_rd_d;
   logic [1:0]           wb_sel_q, wb_sel_d;
   logic [2:0]           funct3_q, funct3_d;
   logic [31:0]          alu_result_q, alu_result_d;
   logic [31:0]          mem_rdata_q, mem_rdata_d;
   logic [31:0]          pc_q, pc_d;
   logic [INSTRET_W-1:0] instret_q, instret_d;

   logic [1:0]           off;
   logic [31:0]          shifted;
   logic [7:0]           byte_w;
   logic [15:0]          half_w;
   logic [31:0]          load_w;
   logic                 is_half;
   logic                 is_word;
   logic                 misalign;
   logic [31:0]          result;
   logic                 we;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         valid_q      <= 1'b0;
         reg_write_q  <= 1'b0;
         addr_rd_q    <= '0;
         wb_sel_q     <= '0;
         funct3_q     <= '0;
         alu_result_q <= '0;
         mem_rdata_q  <= '0;
         pc_q         <= '0;
         instret_q    <= '0;
      end else begin
         valid_q      <= valid_d;
         reg_write_q  <= reg_write_d;
         addr_rd_q    <= addr_rd_d;
         wb_sel_q     <= wb_sel_d;
         funct3_q     <= funct3_d;
         alu_result_q <= alu_result_d;
         mem_rdata_q  <= mem_rdata_d;
         pc_q         <= pc_d;
         instret_q    <= instret_d;
      end
   end

   // The departing instruction retires whenever it leaves unstalled, even on a flush.
   always_comb begin
      valid_d      = valid_q;
      reg_write_d  = reg_write_q;
      addr_rd_d    = addr_rd_q;
      wb_sel_d     = wb_sel_q;
      funct3_d     = funct3_q;
      alu_result_d = alu_result_q;
      mem_rdata_d  = mem_rdata_q;
      pc_d         = pc_q;
      instret_d    = instret_q + {{(INSTRET_W-1){1'b0}}, (valid_q & ~wb.stall)};
      if (wb.flush) begin
         valid_d = 1'b0;
      end else if (!wb.stall) begin
         valid_d      = wb.in_valid;
         reg_write_d  = wb.in_reg_write;
         addr_rd_d    = wb.in_addr_rd;
         wb_sel_d     = wb.in_wb_sel;
         funct3_d     = wb.in_funct3;
         alu_result_d = wb.in_alu_result;
         mem_rdata_d  = wb.in_mem_rdata;
         pc_d         = wb.in_pc;
      end
   end

   always_comb begin
      off     = alu_result_q[1:0];
      shifted = mem_rdata_q >> {off, 3'b000};
      byte_w  = shifted[7:0];
      half_w  = off[1] ? mem_rdata_q[31:16] : mem_rdata_q[15:0];
      is_half = (funct3_q[1:0] == 2'b01);
      is_word = funct3_q[1];
      case (funct3_q)
         3'b000:  load_w = {{24{byte_w[7]}}, byte_w};
         3'b100:  load_w = {24'd0, byte_w};
         3'b001:  load_w = {{16{half_w[15]}}, half_w};
         3'b101:  load_w = {16'd0, half_w};
         default: load_w = mem_rdata_q;
      endcase
      misalign = valid_q & (wb_sel_q == 2'b01) &
                 ((is_half & off[0]) | (is_word & (off != 2'b00)));
      case (wb_sel_q)
         2'b01:   result = load_w;
         2'b10:   result = pc_q + 32'd4;
         default: result = alu_result_q;
      endcase
      we = valid_q & reg_write_q & (addr_rd_q != 5'd0) & ~misalign;
   end

   // Bubbles present all-zero outputs so idle cycles look identical to reset.
   assign wb.write_enable = we;
   assign wb.addr_rd      = valid_q ? addr_rd_q : 5'd0;
   assign wb.data_rd      = valid_q ? result : 32'd0;
   assign wb.fwd_valid    = we;
   assign wb.fwd_addr     = valid_q ? addr_rd_q : 5'd0;
   assign wb.fwd_data     = valid_q ? result : 32'd0;
   assign wb.misalign_err = misalign;
   assign wb.instret      = instret_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Randomized and directed checks of writeback_stage against a behavioural model,
// using a 4-bit counter build for wrap and a 64-bit build for the default width.
module tb_writeback_stage;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        stall = 1'b0, flush = 1'b0;
   logic        in_valid = 1'b0, in_reg_write = 1'b0;
   logic [4:0]  in_addr_rd = '0;
   logic [1:0]  in_wb_sel = '0;
   logic [2:0]  in_funct3 = '0;
   logic [31:0] in_alu_result = '0, in_mem_rdata = '0, in_pc = '0;

   int n_chk = 0;
   int n_fail = 0;

   writeback_stage_if #(.INSTRET_W(4))  if4 ();
   writeback_stage_if #(.INSTRET_W(64)) if64 ();

   assign if4.stall = stall;            assign if64.stall = stall;
   assign if4.flush = flush;            assign if64.flush = flush;
   assign if4.in_valid = in_valid;      assign if64.in_valid = in_valid;
   assign if4.in_reg_write = in_reg_write;   assign if64.in_reg_write = in_reg_write;
   assign if4.in_addr_rd = in_addr_rd;       assign if64.in_addr_rd = in_addr_rd;
   assign if4.in_wb_sel = in_wb_sel;         assign if64.in_wb_sel = in_wb_sel;
   assign if4.in_funct3 = in_funct3;         assign if64.in_funct3 = in_funct3;
   assign if4.in_alu_result = in_alu_result; assign if64.in_alu_result = in_alu_result;
   assign if4.in_mem_rdata = in_mem_rdata;   assign if64.in_mem_rdata = in_mem_rdata;
   assign if4.in_pc = in_pc;                 assign if64.in_pc = in_pc;

   writeback_stage #(.INSTRET_W(4))  dut4  (.clock(clock), .reset_n(reset_n), .wb(if4));
   writeback_stage #(.INSTRET_W(64)) dut64 (.clock(clock), .reset_n(reset_n), .wb(if64));

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: the instruction the stage currently holds, plus a retire count.
   logic        m_valid = 1'b0, m_rw = 1'b0;
   logic [4:0]  m_rd = '0;
   logic [1:0]  m_sel = '0;
   logic [2:0]  m_f3 = '0;
   logic [31:0] m_alu = '0, m_mem = '0, m_pc = '0;
   logic [63:0] m_cnt = '0;

   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         m_valid = 1'b0; m_rw = 1'b0; m_rd = '0; m_sel = '0; m_f3 = '0;
         m_alu = '0; m_mem = '0; m_pc = '0; m_cnt = '0;
      end else begin
         if (m_valid && !stall) m_cnt = m_cnt + 64'd1;
         if (flush) m_valid = 1'b0;
         else if (!stall) begin
            m_valid = in_valid; m_rw = in_reg_write; m_rd = in_addr_rd; m_sel = in_wb_sel;
            m_f3 = in_funct3; m_alu = in_alu_result; m_mem = in_mem_rdata; m_pc = in_pc;
         end
      end
   end

   function automatic logic [31:0] model_load(input logic [2:0] f3, input int off, input logic [31:0] mem);
      logic [31:0] b, h;
      b = (mem >> (8 * off)) & 32'hFF;
      h = (off >= 2) ? (mem >> 16) : (mem & 32'hFFFF);
      case (f3)
         3'd0: return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
         3'd4: return b;
         3'd1: return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
         3'd5: return h;
         default: return mem;
      endcase
   endfunction

   function automatic logic model_mis();
      int off;
      off = int'(m_alu % 4);
      if (!m_valid || m_sel != 2'd1) return 1'b0;
      if ((m_f3 == 3'd1 || m_f3 == 3'd5) && (off % 2 == 1)) return 1'b1;
      if (m_f3 != 3'd0 && m_f3 != 3'd4 && m_f3 != 3'd1 && m_f3 != 3'd5 && off != 0) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [31:0] model_data();
      if (!m_valid) return 32'd0;
      if (m_sel == 2'd1) return model_load(m_f3, int'(m_alu % 4), m_mem);
      if (m_sel == 2'd2) return m_pc + 32'd4;
      return m_alu;
   endfunction

   always @(negedge clock) begin
      logic        e_we;
      logic [31:0] e_data;
      logic [4:0]  e_addr;
      e_data = model_data();
      e_addr = m_valid ? m_rd : 5'd0;
      e_we   = m_valid && m_rw && (m_rd != 5'd0) && !model_mis();
      check("we",        64'(if4.write_enable), 64'(e_we));
      check("addr_rd",   64'(if4.addr_rd),      64'(e_addr));
      check("data_rd",   64'(if4.data_rd),      64'(e_data));
      check("fwd_valid", 64'(if4.fwd_valid),    64'(e_we));
      check("fwd_addr",  64'(if4.fwd_addr),     64'(e_addr));
      check("fwd_data",  64'(if4.fwd_data),     64'(e_data));
      check("misalign",  64'(if4.misalign_err), 64'(model_mis()));
      check("instret4",  64'(if4.instret),      m_cnt % 16);
      check("instret64", if64.instret,          m_cnt);
   end

   task automatic drive(input logic v, input logic rw, input logic [4:0] rd, input logic [1:0] sel,
                        input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] mem,
                        input logic [31:0] pc);
      in_valid = v; in_reg_write = rw; in_addr_rd = rd; in_wb_sel = sel;
      in_funct3 = f3; in_alu_result = alu; in_mem_rdata = mem; in_pc = pc;
   endtask

   task automatic do_reset();
      @(negedge clock); #2 reset_n = 1'b0;
      @(negedge clock); @(negedge clock); #2 reset_n = 1'b1;
   endtask

   initial begin
      logic [31:0] md;
      md = 32'h80FF_7F01;

      // Reset and idle
      @(negedge clock); @(negedge clock);
      check("rst_we",      64'(if4.write_enable), 64'd0);
      check("rst_data",    64'(if4.data_rd),      64'd0);
      check("rst_instret", if64.instret,          64'd0);
      #2 reset_n = 1'b1;
      repeat (3) @(negedge clock);
      check("idle_instret", if64.instret, 64'd0);

      // ALU op
      drive(1, 1, 5'd5, 2'b00, 3'b000, 32'h1234_5678, 32'h0, 32'h0);
      @(negedge clock);
      check("alu_we",   64'(if4.write_enable), 64'd1);
      check("alu_addr", 64'(if4.addr_rd),      64'd5);
      check("alu_data", 64'(if4.data_rd),      64'h1234_5678);

      // Loads
      drive(1, 1, 5'd7, 2'b01, 3'b000, 32'h0000_1003, md, 32'h0);
      @(negedge clock); check("lb_off3",  64'(if4.data_rd), 64'hFFFF_FF80);
      drive(1, 1, 5'd7, 2'b01, 3'b100, 32'h0000_1002, md, 32'h0);
      @(negedge clock); check("lbu_off2", 64'(if4.data_rd), 64'h0000_00FF);
      drive(1, 1, 5'd7, 2'b01, 3'b001, 32'h0000_1002, md, 32'h0);
      @(negedge clock); check("lh_off2",  64'(if4.data_rd), 64'hFFFF_80FF);
      drive(1, 1, 5'd7, 2'b01, 3'b101, 32'h0000_1000, md, 32'h0);
      @(negedge clock); check("lhu_off0", 64'(if4.data_rd), 64'h0000_7F01);
      drive(1, 1, 5'd7, 2'b01, 3'b010, 32'h0000_1000, md, 32'h0);
      @(negedge clock); check("lw",       64'(if4.data_rd), 64'h80FF_7F01);

      // Misaligned
      drive(1, 1, 5'd7, 2'b01, 3'b010, 32'h0000_1002, md, 32'h0);
      @(negedge clock);
      check("lw_mis_err", 64'(if4.misalign_err), 64'd1);
      check("lw_mis_we",  64'(if4.write_enable), 64'd0);
      drive(1, 1, 5'd7, 2'b01, 3'b001, 32'h0000_1001, md, 32'h0);
      @(negedge clock);
      check("lh_mis_err", 64'(if4.misalign_err), 64'd1);
      check("lh_mis_we",  64'(if4.write_enable), 64'd0);

      // JAL, stall, stall+flush, x0 target
      drive(1, 1, 5'd1, 2'b10, 3'b000, 32'h0, 32'h0, 32'h0000_0100);
      @(negedge clock);
      check("jal_data", 64'(if4.data_rd), 64'h104);
      stall = 1'b1;
      drive(1, 1, 5'd9, 2'b00, 3'b000, 32'hDEAD_BEEF, 32'h0, 32'h0);
      repeat (3) begin
         @(negedge clock);
         check("stall_data", 64'(if4.data_rd), 64'h104);
         check("stall_we",   64'(if4.write_enable), 64'd1);
      end
      flush = 1'b1;
      @(negedge clock);
      check("flush_we", 64'(if4.write_enable), 64'd0);
      stall = 1'b0; flush = 1'b0;
      drive(1, 1, 5'd0, 2'b00, 3'b000, 32'h0000_0042, 32'h0, 32'h0);
      @(negedge clock);
      check("x0_we",   64'(if4.write_enable), 64'd0);
      check("x0_data", 64'(if4.data_rd),      64'h42);

      // Counter wrap on the 4-bit build
      drive(0, 0, 5'd0, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0);
      do_reset();
      drive(1, 1, 5'd3, 2'b00, 3'b000, 32'h0000_0011, 32'h0, 32'h0);
      repeat (16) @(negedge clock);
      check("instret_ones", 64'(if4.instret), 64'd15);
      @(negedge clock);
      check("instret_wrap", 64'(if4.instret), 64'd0);
      check("instret64_16", if64.instret,     64'd16);

      // Async reset between edges while a write is pending
      check("pre_rst_we", 64'(if4.write_enable), 64'd1);
      #2 reset_n = 1'b0;
      #1;
      check("async_we",      64'(if4.write_enable), 64'd0);
      check("async_data",    64'(if4.data_rd),      64'd0);
      check("async_instret", if64.instret,          64'd0);
      drive(0, 0, 5'd0, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0);
      @(negedge clock); #2 reset_n = 1'b1;

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         @(negedge clock);
         stall = ($urandom_range(0, 3) == 0);
         flush = ($urandom_range(0, 9) == 0);
         drive($urandom_range(0, 4) != 0, $urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)),
               2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom);
      end
      @(negedge clock);
      stall = 1'b0; flush = 1'b0;
      @(negedge clock);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
